alu_ctrl_issue: RTL and testbench

- Decode/issue stage that produces the 4-bit ALU control code and the two ALU operands consumed by the execute-stage ALU.
- Takes one RV32I instruction per handshake and registers the decoded fields: ALU op, operand A/B, rd, write-enable, branch type and illegal flag.
- Sits between the register-file read and execute, as a single valid/ready pipeline register with stall and flush.

---
 rtl/alu_pkg.sv | 75 +++++++
 rtl/imm_gen.sv | 47 ++++
 rtl/alu_ctrl_issue.sv | 170 +++++++++++++++++
 tb/tb_alu_ctrl_issue.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the decode/issue slice: ALU control codes, RV32I opcodes,
// conditional-branch funct3 values, and helpers mapping funct3 to an ALU code.
// Pure definitions; no state, no timing.
package alu_pkg;

  // ALU control codes consumed by the execute-stage ALU
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b0001;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  // funct7 values that select the base / alternate (SUB, SRA) encodings
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // RV32I base opcodes
  typedef enum logic [6:0] {
    OPC_LUI      = 7'b0110111,
    OPC_AUIPC    = 7'b0010111,
    OPC_JAL      = 7'b1101111,
    OPC_JALR     = 7'b1100111,
    OPC_BRANCH   = 7'b1100011,
    OPC_LOAD     = 7'b0000011,
    OPC_STORE    = 7'b0100011,
    OPC_OP_IMM   = 7'b0010011,
    OPC_OP       = 7'b0110011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  // Conditional-branch funct3 values (010/011 are unassigned)
  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_funct3_e;

  // Register/immediate ALU op: alt selects SUB/SRA over ADD/SRL
  function automatic logic [3:0] alu_op_r(input logic alt, input logic [2:0] funct3);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Compare op the ALU performs to resolve a conditional branch
  function automatic logic [3:0] branch_alu_op(input logic [2:0] funct3);
    logic [3:0] op;
    case (funct3)
      BR_BEQ, BR_BNE: op = ALU_SUB;
      BR_BLT, BR_BGE: op = ALU_SLT;
      default:        op = ALU_SLTU;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate extraction: picks the I/S/B/U/J (or shift-amount) immediate by opcode.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the instruction word.
module imm_gen
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] b_imm;
  logic [31:0] u_imm;
  logic [31:0] j_imm;
  logic [31:0] sh_imm;
  logic [31:0] imm32;

  assign i_imm  = {{20{instr[31]}}, instr[31:20]};
  assign s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b_imm  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm  = {instr[31:12], 12'h000};
  assign j_imm  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign sh_imm = {27'd0, instr[24:20]};

  // Select the immediate format; shifts take the unsigned shamt field
  always_comb begin
    imm32 = 32'd0;
    case (instr[6:0])
      OPC_OP_IMM: imm32 = (instr[13:12] == 2'b01) ? sh_imm : i_imm;
      OPC_LOAD,
      OPC_JALR:   imm32 = i_imm;
      OPC_STORE:  imm32 = s_imm;
      OPC_BRANCH: imm32 = b_imm;
      OPC_LUI,
      OPC_AUIPC:  imm32 = u_imm;
      OPC_JAL:    imm32 = j_imm;
      default:    imm32 = 32'd0;
    endcase
  end

  // Sign-extend the 32-bit immediate to the datapath width
  assign imm = {{(XLEN - 31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/alu_ctrl_issue.sv
// Decode/issue register: RV32I word -> ALU control, operands, rd, wb enable, branch info.
// Latency: one cycle from accepted input to out_valid; back-to-back without bubbles.
// Backpressure: in_ready = !out_valid || out_ready; outputs hold while stalled; flush drops.
module alu_ctrl_issue
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_ctrl,
  output logic [XLEN-1:0] out_op_a,
  output logic [XLEN-1:0] out_op_b,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic [2:0]      out_br_type,
  output logic            out_is_branch,
  output logic            out_illegal
);

  logic [XLEN-1:0] imm;
  logic [6:0]      opc;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic            load;

  logic [3:0]      dec_alu;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic            dec_wb;
  logic            dec_br;
  logic            dec_ill;

  assign opc    = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rd     = in_instr[11:7];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .imm   (imm)
  );

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready;

  // Decode opcode/funct into ALU control, operand muxing, write-back and legality
  always_comb begin
    dec_alu = ALU_ADD;
    dec_a   = '0;
    dec_b   = '0;
    dec_wb  = 1'b0;
    dec_br  = 1'b0;
    dec_ill = 1'b0;
    case (opc)
      OPC_OP: begin
        dec_a  = in_rs1_data;
        dec_b  = in_rs2_data;
        dec_wb = 1'b1;
        if (funct7 == F7_BASE) begin
          dec_alu = alu_op_r(1'b0, funct3);
        end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec_alu = alu_op_r(1'b1, funct3);
        end else begin
          dec_ill = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_a   = in_rs1_data;
        dec_b   = imm;
        dec_wb  = 1'b1;
        // only the right shifts may carry the alternate bit; ADDI etc. never do
        dec_alu = alu_op_r((funct3 == 3'b101) && in_instr[30], funct3);
        if (funct3 == 3'b001 && funct7 != F7_BASE) begin
          dec_ill = 1'b1;
        end
        if (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT) begin
          dec_ill = 1'b1;
        end
      end
      OPC_LOAD: begin
        dec_a  = in_rs1_data;
        dec_b  = imm;
        dec_wb = 1'b1;
      end
      OPC_STORE: begin
        dec_a = in_rs1_data;
        dec_b = imm;
      end
      OPC_LUI: begin
        dec_alu = ALU_PASSB;
        dec_b   = imm;
        dec_wb  = 1'b1;
      end
      OPC_AUIPC: begin
        dec_a  = in_pc;
        dec_b  = imm;
        dec_wb = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        // the ALU forms the link value pc + 4
        dec_a  = in_pc;
        dec_b  = XLEN'(4);
        dec_wb = 1'b1;
      end
      OPC_BRANCH: begin
        dec_a  = in_rs1_data;
        dec_b  = in_rs2_data;
        dec_br = 1'b1;
        if (funct3[2:1] == 2'b01) begin
          dec_ill = 1'b1;
        end else begin
          dec_alu = branch_alu_op(funct3);
        end
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        // legal base-ISA words with no ALU work: issue as a no-op
        dec_wb = 1'b0;
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_alu = ALU_ADD;
      dec_wb  = 1'b0;
    end
    if (rd == 5'd0) begin
      dec_wb = 1'b0;
    end
  end

  // Pipeline register: reset clears, flush kills, load captures, drain empties
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      out_alu_ctrl  <= '0;
      out_op_a      <= '0;
      out_op_b      <= '0;
      out_rd        <= '0;
      out_wb_en     <= 1'b0;
      out_br_type   <= '0;
      out_is_branch <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid     <= 1'b1;
      out_alu_ctrl  <= dec_alu;
      out_op_a      <= dec_a;
      out_op_b      <= dec_b;
      out_rd        <= rd;
      out_wb_en     <= dec_wb;
      out_br_type   <= funct3;
      out_is_branch <= dec_br;
      out_illegal   <= dec_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Bench for alu_ctrl_issue: directed steps then randomized traffic against a reference model.
// Latency: expects the decoded bundle one edge after an accepted handshake.
// Backpressure: drives out_ready/flush freely and tracks the expected valid/ready state.
module tb_alu_ctrl_issue;

  typedef struct packed {
    logic [3:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wb;
    logic        br;
    logic [2:0]  bt;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_ctrl;
  logic [31:0] out_op_a;
  logic [31:0] out_op_b;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic [2:0]  out_br_type;
  logic        out_is_branch;
  logic        out_illegal;

  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;
  logic m_valid = 1'b0;
  logic m_zero  = 1'b0;
  exp_t m_exp   = '0;

  always #5 clk = ~clk;

  alu_ctrl_issue #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .in_rs1_data   (in_rs1_data),
    .in_rs2_data   (in_rs2_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_alu_ctrl  (out_alu_ctrl),
    .out_op_a      (out_op_a),
    .out_op_b      (out_op_b),
    .out_rd        (out_rd),
    .out_wb_en     (out_wb_en),
    .out_br_type   (out_br_type),
    .out_is_branch (out_is_branch),
    .out_illegal   (out_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // 12-bit two's-complement field to a 32-bit value by arithmetic
  function automatic logic [31:0] sx12(input logic [11:0] f);
    return f[11] ? (32'(f) - 32'd4096) : 32'(f);
  endfunction

  // Reference decode written from the instruction-set rules
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    int unsigned op, f3, f7;
    logic [11:0] sfield;
    op = 32'(w[6:0]);
    f3 = 32'(w[14:12]);
    f7 = 32'(w[31:25]);
    sfield = {w[31:25], w[11:7]};
    e = '0;
    e.rd = w[11:7];
    case (op)
      32'h33: begin
        e.a = r1; e.b = r2; e.wb = 1'b1;
        e.ill = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
        e.alu = 4'((f7 == 32) ? 8 + f3 : f3);
      end
      32'h13: begin
        e.a = r1; e.wb = 1'b1;
        e.b = (f3 == 1 || f3 == 5) ? 32'(w[24:20]) : sx12(w[31:20]);
        e.alu = 4'((f3 == 5 && w[30]) ? 8 + f3 : f3);
        e.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
      end
      32'h03: begin e.a = r1; e.b = sx12(w[31:20]); e.wb = 1'b1; end
      32'h23: begin e.a = r1; e.b = sx12(sfield); end
      32'h37: begin e.alu = 4'd15; e.b = w & 32'hFFFF_F000; e.wb = 1'b1; end
      32'h17: begin e.a = pc; e.b = w & 32'hFFFF_F000; e.wb = 1'b1; end
      32'h6F, 32'h67: begin e.a = pc; e.b = 32'd4; e.wb = 1'b1; end
      32'h63: begin
        e.a = r1; e.b = r2; e.br = 1'b1; e.bt = w[14:12];
        e.ill = (f3 == 2 || f3 == 3);
        e.alu = (f3 < 2) ? 4'd8 : ((f3 < 6) ? 4'd2 : 4'd3);
      end
      32'h0F, 32'h73: e.wb = 1'b0;
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin e.alu = 4'd0; e.wb = 1'b0; end
    if (e.rd == 5'd0) e.wb = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  op;
    w = $urandom;
    case ($urandom_range(0, 12))
      0:  op = 7'h33;
      1:  op = 7'h13;
      2:  op = 7'h03;
      3:  op = 7'h23;
      4:  op = 7'h37;
      5:  op = 7'h17;
      6:  op = 7'h6F;
      7:  op = 7'h67;
      8:  op = 7'h63;
      9:  op = 7'h0F;
      10: op = 7'h73;
      11: op = 7'h33;
      default: op = 7'($urandom);
    endcase
    w[6:0] = op;
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: w[31:25] = 7'($urandom);
    endcase
    return w;
  endfunction

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid = v; in_instr = w; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
  endtask

  task automatic compare(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    if (m_valid || m_zero) begin
      chk({tag, ".alu"}, 32'(out_alu_ctrl), 32'(m_exp.alu));
      chk({tag, ".rd"}, 32'(out_rd), 32'(m_exp.rd));
      chk({tag, ".wb"}, 32'(out_wb_en), 32'(m_exp.wb));
      chk({tag, ".ill"}, 32'(out_illegal), 32'(m_exp.ill));
      if (m_zero || !m_exp.ill) begin
        chk({tag, ".op_a"}, out_op_a, m_exp.a);
        chk({tag, ".op_b"}, out_op_b, m_exp.b);
        chk({tag, ".is_br"}, 32'(out_is_branch), 32'(m_exp.br));
        if (m_zero || m_exp.br) chk({tag, ".br_type"}, 32'(out_br_type), 32'(m_exp.bt));
      end
    end
  endtask

  // One clock: check ready, advance the model across the edge, check outputs
  task automatic tick(input string tag);
    logic ld;
    exp_t nx;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(!m_valid || out_ready));
    ld = in_valid && (!m_valid || out_ready);
    nx = ref_decode(in_instr, in_pc, in_rs1_data, in_rs2_data);
    @(posedge clk);
    if (!rst) begin
      m_valid = 1'b0; m_exp = '0; m_zero = 1'b1;
    end else if (flush) begin
      m_valid = 1'b0;
    end else if (ld) begin
      m_valid = 1'b1; m_exp = nx; m_zero = 1'b0;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    compare(tag);
  endtask

  initial begin
    logic [31:0] ill_words [5];
    ill_words[0] = 32'h0000_007F;
    ill_words[1] = 32'h0220_81B3;
    ill_words[2] = 32'h4020_9233;
    ill_words[3] = 32'h4030_9093;
    ill_words[4] = 32'h0020_A063;

    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick("reset");
    tick("reset");
    rst = 1'b1;
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    drive(1'b1, 32'h0020_81B3, 32'h100, 32'd5, 32'd7);
    tick("add");
    chk("add.k_valid", 32'(out_valid), 32'd1);
    chk("add.k_alu", 32'(out_alu_ctrl), 32'h0);
    chk("add.k_op_a", out_op_a, 32'd5);
    chk("add.k_op_b", out_op_b, 32'd7);
    chk("add.k_rd", 32'(out_rd), 32'd3);
    chk("add.k_wb", 32'(out_wb_en), 32'd1);

    drive(1'b1, 32'h4033_5293, 32'h104, 32'h8000_0000, 32'h1234);
    tick("srai");
    chk("srai.k_alu", 32'(out_alu_ctrl), 32'hD);
    chk("srai.k_op_b", out_op_b, 32'd3);

    drive(1'b1, 32'hC000_0093, 32'h108, 32'h55, 32'h66);
    tick("addi");
    chk("addi.k_alu", 32'(out_alu_ctrl), 32'h0);
    chk("addi.k_op_b", out_op_b, 32'hFFFF_FC00);

    drive(1'b1, 32'h1234_50B7, 32'h10C, 32'hDEAD, 32'hBEEF);
    tick("lui");
    chk("lui.k_alu", 32'(out_alu_ctrl), 32'hF);
    chk("lui.k_op_a", out_op_a, 32'h0);
    chk("lui.k_op_b", out_op_b, 32'h1234_5000);
    chk("lui.k_wb", 32'(out_wb_en), 32'd1);
    drive(1'b1, 32'h1234_5037, 32'h110, 32'hDEAD, 32'hBEEF);
    tick("lui_x0");
    chk("lui_x0.k_wb", 32'(out_wb_en), 32'd0);

    // stall: A held three cycles while B waits, then drain+load back-to-back
    drive(1'b1, 32'h0020_81B3, 32'h200, 32'd11, 32'd22);
    tick("stall_a");
    out_ready = 1'b0;
    drive(1'b1, 32'h4020_8233, 32'h204, 32'd100, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      chk("stall.k_in_ready", 32'(in_ready), 32'd0);
      chk("stall.k_op_a", out_op_a, 32'd11);
    end
    out_ready = 1'b1;
    tick("b2b");
    chk("b2b.k_valid", 32'(out_valid), 32'd1);
    chk("b2b.k_alu", 32'(out_alu_ctrl), 32'h8);
    chk("b2b.k_op_a", out_op_a, 32'd100);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick("drain");
    chk("drain.k_valid", 32'(out_valid), 32'd0);

    // flush with a held bundle and a new incoming one
    out_ready = 1'b0;
    drive(1'b1, 32'hC000_0093, 32'h300, 32'd1, 32'd2);
    tick("pre_flush");
    flush = 1'b1;
    drive(1'b1, 32'h1234_50B7, 32'h304, 32'd3, 32'd4);
    tick("flush");
    chk("flush.k_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick("post_flush");
    chk("post_flush.k_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, ill_words[i], 32'h400, 32'd9, 32'd9);
      tick("illegal");
      chk("illegal.k_ill", 32'(out_illegal), 32'd1);
      chk("illegal.k_wb", 32'(out_wb_en), 32'd0);
      chk("illegal.k_valid", 32'(out_valid), 32'd1);
    end

    // reset while stalled discards the held bundle
    drive(1'b1, 32'h0020_81B3, 32'h500, 32'd5, 32'd7);
    tick("pre_rst");
    out_ready = 1'b0;
    drive(1'b1, 32'h1234_50B7, 32'h504, 32'd1, 32'd1);
    tick("rst_stall");
    rst = 1'b0;
    tick("rst_mid");
    chk("rst_mid.k_valid", 32'(out_valid), 32'd0);
    chk("rst_mid.k_op_a", out_op_a, 32'd0);
    chk("rst_mid.k_rd", 32'(out_rd), 32'd0);
    rst = 1'b1; out_ready = 1'b1;

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      tick("rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
